// File: rtl/pll_seq_pkg.sv
// Shared definitions for the pixel-clock PLL lock sequencer.
// Provides the FSM state encoding, default timing constants and an output decode helper.

package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    // 16 MHz reference: 1 us reset pulse, 1 ms lock timeout, 100 us settle.
    localparam int DEF_RESET_CYCLES  = 16;
    localparam int DEF_LOCK_TIMEOUT  = 16000;
    localparam int DEF_STABLE_CYCLES = 1600;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 16;

    // The PLL is held in reset only while pulsing it or after giving up.
    function automatic logic pll_enabled(input state_e s);
        return (s == S_WAIT_LOCK) || (s == S_SETTLE) || (s == S_RUN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, reset (async, active-high), d (async input), q (synchronised output).

module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the iCE40 pixel-clock PLL: pulses RESETB, waits for LOCK
// with bounded retries, and releases the pixel-domain reset after a stable-lock window.
// Ports: clk, reset (async, active-high), pll_locked (async), restart (1-cycle pulse);
//        pll_resetb, rst_out, ready, fail, retries[1:0], state[2:0] (all registered).
// Build option: define PLL_LOCK_LOSS_COUNTER_EN to add the 8-bit lock_loss_cnt output.

module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_resetb,
    output logic               rst_out,
    output logic               ready,
    output logic               fail,
    output logic [1:0]         retries,
`ifdef PLL_LOCK_LOSS_COUNTER_EN
    output logic [7:0]         lock_loss_cnt,
`endif
    output logic [STATE_W-1:0] state
);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       RET_MAX   = 2'(MAX_RETRIES);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       retries_q;
    logic [1:0]       retries_d;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;

        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (cnt_q == LOCK_LAST) begin
                    cnt_d = '0;
                    if (retries_q == RET_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retries_d = retries_q + 2'd1;
                        state_d   = S_PLL_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SETTLE: begin
                // A lock glitch restarts the wait without charging a retry.
                if (!lock_s) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STAB_LAST) begin
                    cnt_d     = '0;
                    retries_d = '0;
                    state_d   = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = S_PLL_RST;
                end
            end
            S_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_PLL_RST;
            end
        endcase

        if (restart) begin
            state_d   = S_PLL_RST;
            cnt_d     = '0;
            retries_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_PLL_RST;
            cnt_q      <= '0;
            retries_q  <= '0;
            pll_resetb <= 1'b0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retries_q  <= retries_d;
            pll_resetb <= pll_enabled(state_d);
            rst_out    <= (state_d != S_RUN);
            ready      <= (state_d == S_RUN);
            fail       <= (state_d == S_FAIL);
        end
    end

`ifdef PLL_LOCK_LOSS_COUNTER_EN
    logic       lock_lost;
    logic [7:0] loss_q;

    // Restart out of RUN is a request, not a lock loss.
    assign lock_lost = (state_q == S_RUN) && !lock_s && !restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if (lock_lost && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

    assign retries = retries_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed lock scenarios plus random
// lock/restart/reset traffic compared every cycle against a behavioural model.

module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb;
    logic       rst_out;
    logic       ready;
    logic       fail;
    logic [1:0] retries;
    logic [2:0] state;
`ifdef PLL_LOCK_LOSS_COUNTER_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_resetb    (pll_resetb),
        .rst_out       (rst_out),
        .ready         (ready),
        .fail          (fail),
        .retries       (retries),
`ifdef PLL_LOCK_LOSS_COUNTER_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .state         (state)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase number, edges spent in the phase, retries used,
    // and the lock level as seen two edges late.
    int m_phase = 0;
    int m_el    = 0;
    int m_tries = 0;
    int m_loss  = 0;
    bit h0 = 1'b0;
    bit h1 = 1'b0;
    bit m_ls;

    // Output table indexed by phase: RESET, WAIT, SETTLE, RUN, FAIL.
    bit t_resetb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit t_rstout [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit t_ready  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit t_fail   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_el    = 0;
            m_tries = 0;
            m_loss  = 0;
            h0      = 1'b0;
            h1      = 1'b0;
        end else begin
            m_ls = h1;
            h1   = h0;
            h0   = pll_locked;
            if (restart) begin
                m_phase = 0;
                m_el    = 0;
                m_tries = 0;
            end else begin
                case (m_phase)
                    0: begin
                        m_el++;
                        if (m_el == RC) begin
                            m_phase = 1;
                            m_el    = 0;
                        end
                    end
                    1: begin
                        if (m_ls) begin
                            m_phase = 2;
                            m_el    = 0;
                        end else begin
                            m_el++;
                            if (m_el == LT) begin
                                m_el = 0;
                                if (m_tries == MR) begin
                                    m_phase = 4;
                                end else begin
                                    m_tries++;
                                    m_phase = 0;
                                end
                            end
                        end
                    end
                    2: begin
                        if (!m_ls) begin
                            m_phase = 1;
                            m_el    = 0;
                        end else begin
                            m_el++;
                            if (m_el == SC) begin
                                m_phase = 3;
                                m_el    = 0;
                                m_tries = 0;
                            end
                        end
                    end
                    3: begin
                        if (!m_ls) begin
                            m_phase = 0;
                            m_el    = 0;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [8:0] ev;
    logic [8:0] av;

    always @(negedge clk) begin
        if (!reset) begin
            ev = {t_resetb[m_phase], t_rstout[m_phase], t_ready[m_phase],
                  t_fail[m_phase], 2'(m_tries), 3'(m_phase)};
            av = {pll_resetb, rst_out, ready, fail, retries, state};
            n_cmp++;
            if (av !== ev) begin
                n_bad++;
                $display("FAIL model t=%0t {resetb,rst_out,ready,fail,retries,state} got %b want %b",
                         $time, av, ev);
            end
`ifdef PLL_LOCK_LOSS_COUNTER_EN
            n_cmp++;
            if (lock_loss_cnt !== 8'(m_loss)) begin
                n_bad++;
                $display("FAIL model lock_loss_cnt got %0d want %0d", lock_loss_cnt, m_loss);
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (state === s) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset      = 1'b1;
        pll_locked = 1'b0;
        restart    = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;

        tick(2);
        chk("reset_state", state, 0);
        chk("reset_resetb", pll_resetb, 0);
        chk("reset_rst_out", rst_out, 1);
        chk("reset_ready", ready, 0);
        chk("reset_fail", fail, 0);
        chk("reset_retries", retries, 0);
        reset = 1'b0;

        // Nominal lock.
        n = 0;
        while (pll_resetb === 1'b0 && n < 50) begin
            n++;
            tick(1);
        end
        chk("resetb_low_cycles", n, RC);
        tick(5);
        pll_locked = 1'b1;
        wait_state(3'd2, 20, ok);
        chk("reach_settle", ok, 1);
        n = 0;
        while (state === 3'd2 && n < 50) begin
            n++;
            tick(1);
        end
        chk("settle_cycles", n, SC);
        chk("nominal_ready", ready, 1);
        chk("nominal_rst_out", rst_out, 0);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        n = 0;
        while (rst_out === 1'b0 && n < 10) begin
            tick(1);
            n++;
        end
        chk("lockloss_edges", n, 3);
        chk("lockloss_ready", ready, 0);
        pll_locked = 1'b1;
        n = 0;
        while (pll_resetb === 1'b0 && n < 50) begin
            n++;
            tick(1);
        end
        chk("relock_resetb_low", n, RC);
        wait_state(3'd3, 60, ok);
        chk("relock_run", ok, 1);
`ifdef PLL_LOCK_LOSS_COUNTER_EN
        chk("lock_loss_cnt", lock_loss_cnt, 1);
`endif

        // Settle glitch.
        do_reset();
        pll_locked = 1'b1;
        wait_state(3'd2, 30, ok);
        chk("glitch_settle", ok, 1);
        tick(2);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_state(3'd1, 10, ok);
        chk("glitch_back_wait", ok, 1);
        chk("glitch_retries", retries, 0);
        wait_state(3'd2, 10, ok);
        n = 0;
        while (state === 3'd2 && n < 50) begin
            n++;
            tick(1);
        end
        chk("glitch_window", n, SC);
        chk("glitch_ready", ready, 1);

        // Never locks.
        do_reset();
        n = 0;
        while (fail !== 1'b1 && n < 200) begin
            n++;
            tick(1);
        end
        chk("fail_cycles", n, 3 * (RC + LT));
        chk("fail_state", state, 4);
        chk("fail_resetb", pll_resetb, 0);
        chk("fail_retries", retries, MR);

        // Restart from FAIL.
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_fail_state", state, 0);
        chk("restart_fail_retries", retries, 0);
        chk("restart_fail_flag", fail, 0);

        // Restart on the final timeout edge.
        do_reset();
        tick(3 * (RC + LT) - 1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_timeout_state", state, 0);
        chk("restart_timeout_fail", fail, 0);

        // Restart mid-SETTLE.
        do_reset();
        pll_locked = 1'b1;
        wait_state(3'd2, 30, ok);
        tick(2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_settle_state", state, 0);
        chk("restart_settle_retries", retries, 0);

        // Async reset between edges during WAIT_LOCK.
        do_reset();
        tick(RC + 1);
        chk("pre_async_state", state, 1);
        reset = 1'b1;
        #1;
        chk("async_state", state, 0);
        chk("async_resetb", pll_resetb, 0);
        chk("async_rst_out", rst_out, 1);
        tick(1);
        reset = 1'b0;

        // Random traffic.
        for (int seg = 0; seg < 150; seg++) begin
            bit lv;
            int len;
            lv  = ($urandom_range(0, 99) < 65);
            len = lv ? $urandom_range(1, 60) : $urandom_range(1, 30);
            pll_locked = lv;
            for (int c = 0; c < len; c++) begin
                restart = ($urandom_range(0, 199) == 0);
                tick(1);
            end
            restart = 1'b0;
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
